btn_enable_gen: RTL

- Conditions a raw push-button input into single-cycle enable pulses for the 4-bit counter stage.
- Sits directly upstream of the counter: its enable_pulse output drives the counter's enable input.
- Processing chain: 2-FF synchronizer, then a counter-based debouncer FSM, then a one-cycle pulse generator with optional auto-repeat while the button is held.
- Replaces the random enable stimulus used in bench-level bring-up with a real, glitch-free source.

---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_enable_gen_if.sv | 15 +
 rtl/btn_enable_gen_sync2ff.sv | 26 ++
 rtl/btn_enable_gen.sv | 116 +++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants for the button conditioning chain
// Purpose: debouncer FSM state encoding used by btn_enable_gen.
// Ports: none (package).
package btn_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

endpackage

// File: rtl/btn_enable_gen_if.sv
// rtl/btn_enable_gen_if.sv - button input / enable output bundle
// Purpose: groups the raw button and the conditioned outputs.
// Signals: btn_in (raw button), enable_pulse (one-cycle enable), btn_level (debounced level).
// Modports: master drives btn_in and observes outputs; slave is the conditioner.
interface btn_enable_gen_if;
  import btn_pkg::*;

  logic btn_in;
  logic enable_pulse;
  logic btn_level;

  modport master (output btn_in, input enable_pulse, input btn_level);
  modport slave  (input btn_in, output enable_pulse, output btn_level);

endinterface

// File: rtl/btn_enable_gen_sync2ff.sv
// rtl/btn_enable_gen_sync2ff.sv - generic two-flop synchronizer
// Purpose: brings an asynchronous input into the clk domain, reset value 0.
// Ports: clk, reset_n (async active-low), d (async input), q (synchronized output).
module sync2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_enable_gen.sv
// rtl/btn_enable_gen.sv - push-button to single-cycle enable pulse generator
// Purpose: synchronizes, debounces and edge-detects a raw button, with optional
//          auto-repeat while held, to drive the downstream counter enable.
// Ports: clk, reset_n (async active-low), bus (slave: btn_in in,
//        enable_pulse out, btn_level out).
module btn_enable_gen
  import btn_pkg::*;
#(
  parameter int N_STABLE      = 4,
  parameter int REPEAT_CYCLES = 0,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  btn_enable_gen_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(N_STABLE - 1);
  // Only consulted when auto-repeat is enabled, so the 0 case never matters.
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_CYCLES - 1);

  logic             s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  sync2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.btn_in),
    .q       (s)
  );

  // Transitions are decided before increments, so a state change always
  // wins over a counter update in the same cycle. Counters only move up to
  // an exact-equality limit and are then cleared, so they cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_PRESS: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_PRESSED;
          pulse_d = 1'b1;
          rep_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end else if (REPEAT_CYCLES > 0) begin
          if (rep_q == REP_LAST) begin
            pulse_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + CNT_ONE;
          end
        end
      end
      ST_WAIT_RELEASE: begin
        if (s) begin
          // Release bounce: back to held without a new press pulse.
          state_d = ST_PRESSED;
          rep_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_WAIT_RELEASE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign bus.enable_pulse = pulse_q;
  assign bus.btn_level    = level_q;

endmodule
